// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive-side sequencing FSM.
package uart_rx_pkg;

  localparam logic [4:0] PRESCALE_MIN = 5'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: steps START/DATA/PARITY/STOP on external bit_end timing.
// Optional saturating frame/parity error counters when UART_RX_ERR_CNT_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_in low
// START  | start bit, start checker enabled
// DATA   | DATA_WIDTH data bits sampled/shifted
// PARITY | optional parity bit checked
// STOP   | stop bit checked, data_valid issued on clean frame
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic [4:0] prescale,
  input  logic [4:0] edge_count,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       cnt_en,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0] frm_err_cnt,
  output logic [7:0] par_err_cnt
`endif
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             par_en_q, par_en_d;
  logic             par_err_q, par_err_d;
  logic             data_valid_q, data_valid_d;
  logic [4:0]       prescale_eff;
  logic             bit_end;

  // Prescale values below the minimum are clamped so a bit never shrinks below 4 clocks.
  assign prescale_eff = (prescale < PRESCALE_MIN) ? PRESCALE_MIN : prescale;
  assign bit_end      = (edge_count == (prescale_eff - 5'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      par_en_q     <= 1'b0;
      par_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      par_en_q     <= par_en_d;
      par_err_q    <= par_err_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    par_en_d     = par_en_q;
    par_err_d    = par_err_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          par_en_d  = par_en;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_d = par_err;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d      = IDLE;
          data_valid_d = !stp_err && !par_err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_en      = (state_q != IDLE);
    strt_chk_en = (state_q == START);
    dat_samp_en = (state_q == DATA);
    deser_en    = (state_q == DATA);
    par_chk_en  = (state_q == PARITY);
    stp_chk_en  = (state_q == STOP);
    data_valid  = data_valid_q;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] frm_err_cnt_q, frm_err_cnt_d;
  logic [7:0] par_err_cnt_q, par_err_cnt_d;

  always_comb begin
    frm_err_cnt_d = frm_err_cnt_q;
    par_err_cnt_d = par_err_cnt_q;
    if ((state_q == STOP) && bit_end && stp_err && (frm_err_cnt_q != 8'hFF))
      frm_err_cnt_d = frm_err_cnt_q + 8'd1;
    if ((state_q == PARITY) && bit_end && par_err && (par_err_cnt_q != 8'hFF))
      par_err_cnt_d = par_err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_err_cnt_q <= 8'd0;
      par_err_cnt_q <= 8'd0;
    end else begin
      frm_err_cnt_q <= frm_err_cnt_d;
      par_err_cnt_q <= par_err_cnt_d;
    end
  end

  assign frm_err_cnt = frm_err_cnt_q;
  assign par_err_cnt = par_err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: emulates edge counter and checkers, compares against a frame-timing model.
module tb_uart_rx_fsm;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [4:0] prescale;
  logic [4:0] edge_count;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       cnt_en;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] frm_err_cnt;
  logic [7:0] par_err_cnt;
`endif

  uart_rx_fsm #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .edge_count  (edge_count),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .cnt_en      (cnt_en),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .frm_err_cnt (frm_err_cnt),
    .par_err_cnt (par_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int peff(input logic [4:0] p);
    return (p < 5'd4) ? 4 : int'(p);
  endfunction

  // Environment: edge counter and checkers, reporting their configured result at bit end only.
  logic       cfg_glitch, cfg_perr, cfg_serr;
  logic [4:0] peff_now;
  logic       bit_end_env;

  assign peff_now    = 5'(peff(prescale));
  assign bit_end_env = (edge_count == peff_now - 5'd1);
  assign strt_glitch = cfg_glitch & strt_chk_en & bit_end_env;
  assign par_err     = cfg_perr & par_chk_en & bit_end_env;
  assign stp_err     = cfg_serr & stp_chk_en & bit_end_env;

  always @(posedge clk) begin
    if (rst || !cnt_en) edge_count <= 5'd0;
    else if (edge_count == peff_now - 5'd1) edge_count <= 5'd0;
    else edge_count <= edge_count + 5'd1;
  end

  // Frame model: k counts clocks since the first START cycle; bit phases are k / P.
  bit m_busy = 0;
  bit m_dv = 0;
  bit m_par = 0;
  bit m_perr = 0;
  int m_k = 0;
  int m_p = 4;
  int m_len = 0;
  int m_frm_cnt = 0;
  int m_par_cnt = 0;

  always @(posedge clk) begin
    m_dv = 0;
    if (rst) begin
      m_busy = 0; m_par = 0; m_perr = 0; m_frm_cnt = 0; m_par_cnt = 0;
    end else if (m_busy) begin
      if (m_k == m_p - 1 && cfg_glitch) begin
        m_busy = 0;
      end else if (m_k == m_len - 1) begin
        m_busy = 0;
        if (cfg_serr && m_frm_cnt < 255) m_frm_cnt++;
        m_dv = !cfg_serr && !m_perr;
      end else begin
        if (m_par && m_k == (W + 2) * m_p - 1 && cfg_perr) begin
          m_perr = 1;
          if (m_par_cnt < 255) m_par_cnt++;
        end
        m_k++;
      end
    end else if (!rx_in) begin
      m_busy = 1; m_k = 0; m_p = peff(prescale); m_par = par_en; m_perr = 0;
      m_len = (2 + W + (par_en ? 1 : 0)) * m_p;
    end
  end

  bit chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      int ph;
      logic [6:0] exp_v, act_v;
      ph = m_busy ? (m_k / m_p) : -1;
      exp_v[6] = m_busy;
      exp_v[5] = m_busy && ph == 0;
      exp_v[4] = m_busy && ph >= 1 && ph <= W;
      exp_v[3] = m_busy && ph >= 1 && ph <= W;
      exp_v[2] = m_busy && m_par && ph == W + 1;
      exp_v[1] = m_busy && ph == W + 1 + (m_par ? 1 : 0);
      exp_v[0] = m_dv;
      act_v = {cnt_en, strt_chk_en, dat_samp_en, deser_en, par_chk_en, stp_chk_en, data_valid};
      chk("cycle_outputs{cnt,strt,samp,deser,par,stp,dv}", 32'(act_v), 32'(exp_v));
`ifdef UART_RX_ERR_CNT_EN
      chk("cycle_frm_err_cnt", 32'(frm_err_cnt), 32'(m_frm_cnt));
      chk("cycle_par_err_cnt", 32'(par_err_cnt), 32'(m_par_cnt));
`endif
    end
  end

  // One frame from rx_in falling until the FSM returns to IDLE; par_en is flipped mid-frame.
  task automatic run_frame(input string nm, input logic [4:0] p, input logic pe, input logic [7:0] dat,
                           input int low_cycles, input logic g, input logic pr, input logic sr,
                           input int exp_end, input int exp_dv, input int exp_deser, input int exp_parc);
    int n, ph, deser, parc, dv_at, pp;
    prescale = p; par_en = pe; cfg_glitch = g; cfg_perr = pr; cfg_serr = sr;
    pp = peff(p);
    rx_in = 1'b0;
    @(posedge clk); #2;
    n = 1; deser = 0; parc = 0;
    par_en = ~pe;
    while (cnt_en && n < 1000) begin
      if (deser_en) deser++;
      if (par_chk_en) parc++;
      ph = (n - 1) / pp;
      if (ph == 0) rx_in = (n < low_cycles) ? 1'b0 : 1'b1;
      else if (ph <= W) rx_in = dat[ph-1];
      else if (ph == W + 1 && pe) rx_in = ^dat;
      else rx_in = 1'b1;
      @(posedge clk); #2;
      n++;
    end
    dv_at = data_valid ? n : 0;
    rx_in = 1'b1;
    par_en = pe;
    chk({nm, "_end_cycle"}, 32'(n), 32'(exp_end));
    chk({nm, "_dv_cycle"}, 32'(dv_at), 32'(exp_dv));
    chk({nm, "_deser_cycles"}, 32'(deser), 32'(exp_deser));
    chk({nm, "_parity_cycles"}, 32'(parc), 32'(exp_parc));
  endtask

  initial begin
    int dv_seen;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 5'd8;
    cfg_glitch = 1'b0; cfg_perr = 1'b0; cfg_serr = 1'b0;
    @(posedge clk); #2;
    chk_on = 1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("reset_enables", 32'({cnt_en, strt_chk_en, dat_samp_en, deser_en, par_chk_en, stp_chk_en}), 32'd0);
    chk("reset_data_valid", 32'(data_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2;

    run_frame("p8_a5", 5'd8, 1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 81, 81, 64, 0);
    run_frame("p16_par_ok", 5'd16, 1'b1, 8'h3C, 16, 1'b0, 1'b0, 1'b0, 177, 177, 128, 16);
    run_frame("p16_par_err", 5'd16, 1'b1, 8'h3C, 16, 1'b0, 1'b1, 1'b0, 177, 0, 128, 16);
`ifdef UART_RX_ERR_CNT_EN
    chk("par_err_cnt_after_parity_error", 32'(par_err_cnt), 32'd1);
`endif
    cfg_perr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    run_frame("glitch", 5'd8, 1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0, 9, 0, 0, 0);
    chk("glitch_cnt_en_low", 32'(cnt_en), 32'd0);
    cfg_glitch = 1'b0;
    run_frame("stop_err", 5'd8, 1'b0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 81, 0, 64, 0);
`ifdef UART_RX_ERR_CNT_EN
    chk("frm_err_cnt_after_stop_error", 32'(frm_err_cnt), 32'd1);
`endif
    run_frame("after_stop_err", 5'd8, 1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b0, 81, 81, 64, 0);
    run_frame("p2_clamped", 5'd2, 1'b0, 8'h81, 4, 1'b0, 1'b0, 1'b0, 41, 41, 32, 0);
    run_frame("p31_par", 5'd31, 1'b1, 8'hFF, 31, 1'b0, 1'b0, 1'b0, 342, 342, 248, 31);

    // Reset in the middle of data bit 3 (prescale 4): START is cycles 1..4, bit 3 is cycles 17..20.
    prescale = 5'd4; par_en = 1'b0;
    rx_in = 1'b0;
    @(posedge clk); #2;
    rx_in = 1'b1;
    repeat (17) @(posedge clk);
    #2;
    chk("pre_reset_in_data", 32'(deser_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("mid_reset_enables", 32'({cnt_en, strt_chk_en, dat_samp_en, deser_en, par_chk_en, stp_chk_en}), 32'd0);
    chk("mid_reset_data_valid", 32'(data_valid), 32'd0);
    dv_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (data_valid) dv_seen++;
    end
    chk("no_dv_after_abort", 32'(dv_seen), 32'd0);
    run_frame("after_reset", 5'd4, 1'b0, 8'h69, 4, 1'b0, 1'b0, 1'b0, 41, 41, 32, 0);

    repeat (3) @(posedge clk);
    #2;
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (5..8 legal).
REQ-002 SHALL have ports:
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  rx_in  in  1  synchronized serial line, idle high
  par_en  in  1  parity bit present in frame
  prescale  in  5  clocks per bit, legal 4..31
  edge_count  in  5  external edge counter value, counts 0..prescale-1 while cnt_en=1, held 0 when cnt_en=0
  strt_glitch  in  1  start checker result, valid at bit end
  par_err  in  1  parity checker result, valid at bit end
  stp_err  in  1  stop checker result, valid at bit end
  cnt_en  out  1  enables external edge counter
  dat_samp_en  out  1  enables data sampler
  deser_en  out  1  enables deserializer shift
  strt_chk_en  out  1  enables start checker
  par_chk_en  out  1  enables parity checker
  stp_chk_en  out  1  enables stop checker
  data_valid  out  1  one-cycle pulse, received byte good

Function
REQ-003 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-004 SHALL define bit_end = (edge_count == prescale_eff-1); prescale_eff = max(prescale,4).
REQ-005 SHALL, in IDLE, go to START on the edge where rx_in=0; else stay IDLE.
REQ-006 SHALL latch par_en into par_en_q on IDLE->START; mid-frame par_en changes ignored.
REQ-007 SHALL, in START at bit_end: strt_glitch=1 -> IDLE; else -> DATA with bit_idx cleared to 0.
REQ-008 SHALL, in DATA at bit_end, increment bit_idx; at bit_idx==DATA_WIDTH-1 go to PARITY if par_en_q else STOP.
REQ-009 SHALL, in PARITY at bit_end, latch par_err into par_err_q and go to STOP; par_err_q cleared on IDLE->START.
REQ-010 SHALL, in STOP at bit_end, go to IDLE and pulse data_valid for exactly the next cycle iff stp_err=0 and par_err_q=0.
REQ-011 SHALL drive outputs combinationally from state: cnt_en = state!=IDLE; strt_chk_en in START; dat_samp_en and deser_en in DATA; par_chk_en in PARITY; stp_chk_en in STOP.
REQ-012 SHALL register data_valid (no combinational path from inputs).
REQ-013 SHALL have frame length (START entry to data_valid) = (2+DATA_WIDTH+par_en_q)*prescale_eff + 1 cycles.
REQ-014 SHALL treat a frame error (stp_err or par_err_q) as silent drop: no data_valid, return IDLE, next start accepted normally.
REQ-015 SHALL ignore rx_in outside IDLE; only checker inputs affect transitions.

Reset
REQ-016 SHALL, with rst=1 at a rising edge, force state=IDLE, bit_idx=0, par_en_q=0, par_err_q=0, data_valid=0; all enables 0 the following cycle.
REQ-017 SHALL abort any frame in progress on reset, no data_valid generated.

Configuration
REQ-018 SHALL, when UART_RX_ERR_CNT_EN is defined, add outputs frm_err_cnt[7:0] and par_err_cnt[7:0], saturating at 255, cleared by rst; frm_err_cnt increments on STOP bit_end with stp_err=1, par_err_cnt on PARITY bit_end with par_err=1.
REQ-019 SHALL, without UART_RX_ERR_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-020 SHALL place the state enum and PRESCALE_MIN=4 constant in shared package uart_rx_pkg.
REQ-021 SHALL be a single module; error counters in one generate/ifdef region, no sub-module.

Verification
REQ-022 prescale=8, par_en=0, frame 0xA5 LSB-first, good stop -> deser_en high 64 cycles, data_valid pulse at cycle 81 after START entry.
REQ-023 prescale=16, par_en=1, par_err=0 -> PARITY state 16 cycles, data_valid at cycle 177; with par_err=1 at parity bit_end -> no data_valid, par_err_cnt=1 (macro on).
REQ-024 rx_in low 3 cycles then high, strt_glitch=1 at START bit_end -> IDLE, no DATA entry, cnt_en low next cycle.
REQ-025 stp_err=1 at STOP bit_end -> no data_valid; immediate second good frame -> data_valid asserted once.
REQ-026 rst=1 mid-DATA (bit_idx=3) -> next cycle IDLE, all enables 0, data_valid never pulses; prescale=2 -> timing as prescale=4.
